ham_dec_sched: RTL
==================

# ham_dec_sched

Shared-decoder scheduler for the Hamming(7,4) path. Two requester channels present 7-bit codewords over valid/ready. The block arbitrates round-robin and drives one instance of the syndrome/correction datapath. It returns corrected 4-bit data with error flags and the source id, and keeps a saturating error count per requester. It sits between the link receivers and the consumer logic, so only one decoder instance is needed.

## Interface
- `CNT_W`, default 8: width of each per-requester error counter.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a codeword.
- `req0_code` in 7: requester 0 codeword. Bit i is Hamming position i+1.
- `req0_ready` out 1: requester 0 codeword accepted this cycle when high with `req0_valid`.
- `req1_valid`, `req1_code`, `req1_ready`: same as requester 0, for requester 1.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 4: corrected data, {pos7,pos6,pos5,pos3}.
- `out_src` out 1: id of the requester that supplied the codeword.
- `out_err` out 1: syndrome was nonzero.
- `out_pos` out 3: syndrome value, which is the error position; 0 means none.
- `cnt_clr` in 1: synchronous clear of both counters.
- `err_cnt0`, `err_cnt1` out CNT_W: saturating count of nonzero-syndrome codewords per requester.

## Operation
- FSM states: IDLE, DEC, OUT.
  - IDLE: grant one valid requester and register its codeword and id, then go to DEC. If no requester is valid, stay in IDLE.
  - DEC: compute the syndrome on the registered word and register the results, then go to OUT.
  - OUT: hold `out_valid`. When `out_ready` is high, go to IDLE.
- Handshake:
  - A requester's `ready` is high only in IDLE, only for the granted channel, and only combinationally with its `valid`.
  - Each `ready` is a single-cycle pulse.
  - `ready` never depends on `out_ready`.
- Round-robin arbitration:
  - The priority pointer starts at 0.
  - After a grant, the pointer moves to the other requester.
  - When both requesters are valid, the channel the pointer names wins.
  - When only one requester is valid, it wins regardless of the pointer, and the pointer still moves.
- Syndrome, with w the registered codeword:
  - c1 = w0^w2^w4^w6
  - c2 = w1^w2^w5^w6
  - c3 = w3^w4^w5^w6
  - pos = {c3,c2,c1}
- Correction: if pos≠0, invert bit pos-1, then extract the data bits. Errors in parity bits (pos 1, 2, 4) leave the data unchanged.
- Double errors are miscorrected silently. This is single-error-correct only, with no detection flag for double errors.
- Counters:
  - The source counter increments on the OUT→IDLE transition when `out_err`=1.
  - Counters saturate at 2^CNT_W-1.
  - `cnt_clr` has priority over a coincident increment; the result is 0.
- `out_*` outputs stay stable throughout OUT until accepted.

## Timing
- Reset values:
  - state IDLE, pointer 0.
  - `out_valid`=0, `out_data`=0, `out_src`=0, `out_err`=0, `out_pos`=0.
  - `req*_ready`=0 (no valid requesters during reset), counters 0.
- `rst` has priority over everything. Reset in DEC or OUT drops the in-flight word, with no output and no count.
- Latency: an accept in cycle N gives `out_valid` in cycle N+2.
- Throughput: with `out_ready` tied high, one result per 3 cycles.
- A result handshake in cycle M allows the next accept in cycle M+1 at the earliest.
- Backpressure: `out_ready` low holds OUT indefinitely, and neither requester sees `ready` during that time.

## Structure
- Package `ham_pkg`:
  - State enum (IDLE/DEC/OUT).
  - Widths: code 7, data 4, syndrome 3.
  - Parity-position constants.
- Sub-module `ham_syndrome_corr`, purely combinational:
  - Input: 7-bit word.
  - Outputs: 4-bit corrected data, 3-bit pos, err.
  - Instantiated once, between the DEC input register and the DEC output register.

## Test plan
- Clean word: req0 sends 7'b1010101 → in cycle N+2, `out_data`=4'b1011, `out_pos`=0, `out_err`=0, `out_src`=0; `err_cnt0` stays 0.
- Data error: req1 sends 7'b0010101 (position 7 flipped) → `out_data`=4'b1011, `out_pos`=7, `out_err`=1, `out_src`=1; `err_cnt1`=1.
- Parity error: req0 sends 7'b1010100 → `out_pos`=1, `out_data`=4'b1011, `err_cnt0` increments.
- Arbitration: both requesters valid continuously from reset → grant order 0,1,0,1, with `out_src` alternating in the same order.
- Backpressure: `out_ready` held low 5 cycles → `out_*` constant, both `ready` low; releasing `out_ready` gives the next grant in the following cycle.
- Counters:
  - Force CNT_W=2 and send 5 errored words on req0 → `err_cnt0` saturates at 3.
  - `cnt_clr` coincident with an increment → 0.
  - `rst` asserted in DEC → no `out_valid`, counters unchanged.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming(7,4) decode scheduler: widths,
// FSM state encoding, parity positions and the data-bit extraction helper.
package ham_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Hamming positions (1-based) that carry parity rather than data.
  localparam logic [SYN_W-1:0] POS_P1 = 3'd1;
  localparam logic [SYN_W-1:0] POS_P2 = 3'd2;
  localparam logic [SYN_W-1:0] POS_P4 = 3'd4;

  // Scheduler states: waiting for a requester, decoding, presenting a result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_OUT  = 2'd2
  } ham_state_e;

  // Data bits live at positions 7,6,5,3, i.e. word bits 6,5,4,2.
  function automatic logic [DATA_W-1:0] ham_extract(input logic [CODE_W-1:0] w);
    return {w[6], w[5], w[4], w[2]};
  endfunction

  // True when a nonzero syndrome points at a parity bit; data is then untouched.
  function automatic logic ham_is_parity_pos(input logic [SYN_W-1:0] pos);
    return (pos == POS_P1) || (pos == POS_P2) || (pos == POS_P4);
  endfunction

endpackage

// File: rtl/ham_syndrome_corr.sv
// Combinational Hamming(7,4) syndrome and single-error correction.
// Double errors produce a nonzero syndrome and are miscorrected; no
// double-error detection is attempted.
module ham_syndrome_corr
  import ham_pkg::*;
(
  input  logic [CODE_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic [SYN_W-1:0]  pos,
  output logic              err
);

  logic c1;
  logic c2;
  logic c3;
  logic [CODE_W-1:0] fixed;

  // Syndrome bits, flip of the indicated position, then data extraction.
  always_comb begin
    c1    = word[0] ^ word[2] ^ word[4] ^ word[6];
    c2    = word[1] ^ word[2] ^ word[5] ^ word[6];
    c3    = word[3] ^ word[4] ^ word[5] ^ word[6];
    pos   = {c3, c2, c1};
    err   = (pos != '0);
    fixed = word;
    if (err) begin
      fixed[pos - 3'd1] = ~word[pos - 3'd1];
    end
    data  = ham_extract(fixed);
  end

endmodule

// File: rtl/ham_dec_sched.sv
// Round-robin scheduler sharing one Hamming(7,4) decoder between two
// requesters, with per-requester saturating error counters.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. Requester ready is a combinational single-cycle
// pulse, only in IDLE, only for the granted channel, and never depends on
// out_ready. out_valid is held with stable out_* until out_ready is seen.
module ham_dec_sched
  import ham_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CODE_W-1:0] req0_code,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CODE_W-1:0] req1_code,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_err,
  output logic [SYN_W-1:0]  out_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ham_state_e state;
  ham_state_e state_nxt;

  logic              ptr;
  logic [CODE_W-1:0] code_q;
  logic              src_q;

  logic              grant_load;
  logic              grant_src;
  logic              dec_load;
  logic              out_fire;

  logic [DATA_W-1:0] corr_data;
  logic [SYN_W-1:0]  corr_pos;
  logic              corr_err;

  logic              inc0;
  logic              inc1;

  ham_syndrome_corr u_corr (
    .word (code_q),
    .data (corr_data),
    .pos  (corr_pos),
    .err  (corr_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, arbitration and handshake strobes.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_load = 1'b0;
    grant_src  = 1'b0;
    dec_load   = 1'b0;
    out_fire   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          // Requester 1 wins when it is alone or when the pointer names it.
          grant_src  = req1_valid && (!req0_valid || ptr);
          grant_load = 1'b1;
          req0_ready = !grant_src;
          req1_ready = grant_src;
          state_nxt  = ST_DEC;
        end
      end
      ST_DEC: begin
        dec_load  = 1'b1;
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Input capture and round-robin pointer; pointer always moves past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      code_q <= '0;
      src_q  <= 1'b0;
    end else if (grant_load) begin
      ptr    <= ~grant_src;
      code_q <= grant_src ? req1_code : req0_code;
      src_q  <= grant_src;
    end
  end

  // Result register, loaded once in DEC and held through OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_pos  <= '0;
      out_err  <= 1'b0;
      out_src  <= 1'b0;
    end else if (dec_load) begin
      out_data <= corr_data;
      out_pos  <= corr_pos;
      out_err  <= corr_err;
      out_src  <= src_q;
    end
  end

  assign inc0 = out_fire && out_err && (out_src == 1'b0);
  assign inc1 = out_fire && out_err && (out_src == 1'b1);

  // Saturating error counters; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt0 <= '0;
      err_cnt1 <= '0;
    end else begin
      if (inc0 && (err_cnt0 != CNT_MAX)) begin
        err_cnt0 <= err_cnt0 + 1'b1;
      end
      if (inc1 && (err_cnt1 != CNT_MAX)) begin
        err_cnt1 <= err_cnt1 + 1'b1;
      end
    end
  end

  assign dbg_state = state;

endmodule
